// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 timing with a framebuffer-backed grey image.
// Ports: clk/rst, enable, image_select, mem_* (1-cycle read), hsync/vsync,
// rgb_out, frame_start. Optional SCANOUT_BORDER_EN: white ring around image.
module vga_scanout #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int X0    = 192,
  parameter int Y0    = 112,
  parameter int AW    = 16,
  parameter int BASE0 = 0,
  parameter int BASE1 = 16384
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          image_select,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [31:0]   mem_rdata,
  output logic          hsync,
  output logic          vsync,
  output logic [23:0]   rgb_out,
  output logic          frame_start
);

  localparam logic [31:0] XL = 32'(X0);
  localparam logic [31:0] XR = 32'(X0 + IMG_W);
  localparam logic [31:0] YT = 32'(Y0);
  localparam logic [31:0] YB = 32'(Y0 + IMG_H);
  localparam logic [31:0] WQ = 32'(IMG_W / 4);

  logic [9:0]    hc, vc;
  logic          en_lat, sel_lat;
  logic          en_cur, sel_cur;
  logic          at_org, vis, in_img;
  logic [31:0]   h, v, dx, dy;
  logic [31:0]   base_cur, offset;
  logic [AW-1:0] addr_calc, addr_q;

  logic          show1, hs1, vs1, fs1;
  logic [1:0]    lane1;
  logic [7:0]    pixel;
  logic [23:0]   rgb_next;

  assign at_org = (hc == 10'd0) && (vc == 10'd0);

  // Frame controls take effect from pixel (0,0) itself.
  assign en_cur  = at_org ? enable : en_lat;
  assign sel_cur = at_org ? image_select : sel_lat;

  assign h   = 32'(hc);
  assign v   = 32'(vc);
  assign vis = (hc < 10'd640) && (vc < 10'd480);

  assign in_img = (h >= XL) && (h < XR) &&
                  (v >= YT) && (v < YB);

  assign dx       = h - XL;
  assign dy       = v - YT;
  assign base_cur = sel_cur ? 32'(BASE1) : 32'(BASE0);
  assign offset   = dy * WQ + (dx >> 2);
  assign addr_calc = AW'(base_cur + offset);

  assign mem_rd_en = rst & in_img & en_cur;
  assign mem_addr  = mem_rd_en ? addr_calc : addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc      <= '0;
      vc      <= '0;
      en_lat  <= 1'b0;
      sel_lat <= 1'b0;
      addr_q  <= '0;
    end else begin
      en_lat  <= en_cur;
      sel_lat <= sel_cur;
      addr_q  <= mem_addr;
      if (hc == 10'd799) begin
        hc <= '0;
        vc <= (vc == 10'd524) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  assign pixel = mem_rdata[{lane1, 3'b000} +: 8];

`ifdef SCANOUT_BORDER_EN
  logic ring, bord1;

  assign ring = (h + 32'd1 >= XL) && (h <= XR) &&
                (v + 32'd1 >= YT) && (v <= YB) &&
                !in_img;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bord1 <= 1'b0;
    else      bord1 <= ring & en_cur & vis;
  end

  always_comb begin
    rgb_next = '0;
    unique case (1'b1)
      show1:   rgb_next = {3{pixel}};
      bord1:   rgb_next = 24'hFFFFFF;
      default: rgb_next = '0;
    endcase
  end
`else
  always_comb begin
    rgb_next = '0;
    if (show1) rgb_next = {3{pixel}};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      show1       <= 1'b0;
      lane1       <= 2'd0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      fs1         <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      rgb_out     <= '0;
    end else begin
      show1       <= mem_rd_en & vis;
      lane1       <= dx[1:0];
      hs1         <= !((hc >= 10'd656) && (hc <= 10'd751));
      vs1         <= !((vc >= 10'd490) && (vc <= 10'd491));
      fs1         <= at_org;
      hsync       <= hs1;
      vsync       <= vs1;
      frame_start <= fs1;
      rgb_out     <= rgb_next;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: randomized scoreboard bench for vga_scanout.
// A per-cycle reference model feeds an expected-output queue.
module tb_vga_scanout;

  localparam int P_W  = 64;
  localparam int P_H  = 6;
  localparam int P_X0 = 192;
  localparam int P_Y0 = 3;
  localparam int P_AW = 16;
  localparam int P_B0 = 0;
  localparam int P_B1 = 16384;
  localparam int LINES = 10;

`ifdef SCANOUT_BORDER_EN
  localparam logic [23:0] BEXP = 24'hFFFFFF;
  localparam bit BORDER = 1'b1;
`else
  localparam logic [23:0] BEXP = 24'h000000;
  localparam bit BORDER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic image_select = 1'b0;
  logic [P_AW-1:0] mem_addr;
  logic mem_rd_en;
  logic [31:0] mem_rdata = 32'd0;
  logic hsync, vsync, frame_start;
  logic [23:0] rgb_out;

  logic [31:0] mem [0:65535];

  int n_chk = 0;
  int n_err = 0;

  vga_scanout #(
    .IMG_W(P_W), .IMG_H(P_H), .X0(P_X0), .Y0(P_Y0),
    .AW(P_AW), .BASE0(P_B0), .BASE1(P_B1)
  ) dut (
    .clk(clk), .rst(rst),
    .enable(enable), .image_select(image_select),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata),
    .hsync(hsync), .vsync(vsync),
    .rgb_out(rgb_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [23:0] rgb;
    logic hs, vs, fs;
    int hc, vc;
  } exp_t;

  exp_t q[$];

  // Reference model: position from elapsed cycles, frame controls
  // captured at each frame origin, pixels read from the memory array.
  int t = 0;
  bit m_en = 0, m_sel = 0;
  int m_addr = 0;

  always @(negedge clk) begin
    exp_t e;
    int hc, vc, base, lane;
    bit inimg, ring, vis, rd;
    logic [31:0] word;
    if (!rst) begin
      q.delete();
      t = 0;
      m_en = 0;
      m_sel = 0;
      m_addr = 0;
      e.rgb = 24'd0; e.hs = 1; e.vs = 1; e.fs = 0;
      e.hc = -1; e.vc = -1;
      q.push_back(e);
    end else begin
      hc = t % 800;
      vc = (t / 800) % 525;
      if (hc == 0 && vc == 0) begin
        m_en = enable;
        m_sel = image_select;
      end
      base = m_sel ? P_B1 : P_B0;
      inimg = hc >= P_X0 && hc < P_X0 + P_W &&
              vc >= P_Y0 && vc < P_Y0 + P_H;
      ring = hc >= P_X0 - 1 && hc <= P_X0 + P_W &&
             vc >= P_Y0 - 1 && vc <= P_Y0 + P_H && !inimg;
      vis = hc < 640 && vc < 480;
      rd = inimg && m_en;
      if (rd)
        m_addr = (base + (((vc - P_Y0) * P_W + (hc - P_X0)) / 4))
                 % 65536;
      chk("rd_en", 32'(mem_rd_en), 32'(rd));
      chk("addr", 32'(mem_addr), 32'(m_addr));
      e.rgb = 24'd0;
      if (vis && rd) begin
        word = mem[m_addr];
        lane = (hc - P_X0) % 4;
        e.rgb = {3{8'((word >> (8 * lane)) & 32'hFF)}};
      end else if (BORDER && vis && ring && m_en) begin
        e.rgb = 24'hFFFFFF;
      end
      e.hs = !(hc >= 656 && hc <= 751);
      e.vs = !(vc >= 490 && vc <= 491);
      e.fs = (hc == 0 && vc == 0);
      e.hc = hc;
      e.vc = vc;
      q.push_back(e);
      t++;
    end
  end

  bit dir_a = 0;
  int hcnt = 0;
  logic [23:0] pat [4] = '{24'h111111, 24'h222222,
                           24'h333333, 24'h444444};

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      chk("rst_rgb", 32'(rgb_out), 32'd0);
      chk("rst_hs", 32'(hsync), 32'd1);
      chk("rst_vs", 32'(vsync), 32'd1);
      chk("rst_fs", 32'(frame_start), 32'd0);
      chk("rst_rd", 32'(mem_rd_en), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
    end else if (q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("rgb", 32'(rgb_out), 32'(e.rgb));
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
      chk("fs", 32'(frame_start), 32'(e.fs));
      if (dir_a && e.vc == P_Y0 && e.hc >= P_X0 && e.hc < P_X0 + 4)
        chk("pix0", 32'(rgb_out), 32'(pat[e.hc - P_X0]));
      if (dir_a && e.vc == P_Y0 &&
          (e.hc == P_X0 - 1 || e.hc == P_X0 + P_W))
        chk("border", 32'(rgb_out), 32'(BEXP));
      if (e.hc >= 0) begin
        if (e.hc == 0) hcnt = 0;
        if (!hsync) hcnt++;
        if (e.hc == 799) chk("hs_len", 32'(hcnt), 32'd96);
      end
    end
  end

  int tcur = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
      tcur++;
    end
  endtask

  task automatic goto(input int target);
    if (target > tcur) tick(target - tcur);
  endtask

  task automatic pulse_reset(input bit en, input bit sel);
    rst = 1'b0;
    #1;
    chk("async_rgb", 32'(rgb_out), 32'd0);
    chk("async_hs", 32'(hsync), 32'd1);
    chk("async_vs", 32'(vsync), 32'd1);
    chk("async_fs", 32'(frame_start), 32'd0);
    chk("async_rd", 32'(mem_rd_en), 32'd0);
    chk("async_addr", 32'(mem_addr), 32'd0);
    tick(2);
    enable = en;
    image_select = sel;
    rst = 1'b1;
    tcur = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[P_B0] = 32'h44332211;
    #1;
    pulse_reset(1'b1, 1'b0);
    dir_a = 1;
    tick(2);
    chk("fs_release", 32'(frame_start), 32'd1);
    tick(1);
    chk("fs_pulse_end", 32'(frame_start), 32'd0);
    goto((P_Y0 + 2) * 800 + 300);
    image_select = 1'b1;
    goto((P_Y0 + 6) * 800 + 500);
    dir_a = 0;
    pulse_reset(1'b1, 1'b1);
    goto(P_Y0 * 800 + P_X0);
    chk("sel1_rd", 32'(mem_rd_en), 32'd1);
    chk("sel1_addr", 32'(mem_addr), 32'(P_B1));
    goto(LINES * 800);
    pulse_reset(1'b0, 1'b0);
    goto(P_Y0 * 800 + P_X0 + 5);
    enable = 1'b1;
    goto(LINES * 800);
    for (int k = 0; k < 4; k++) begin
      pulse_reset(1'($urandom), 1'($urandom));
      for (int j = 0; j < LINES * 8; j++) begin
        tick(100);
        if ($urandom_range(0, 3) == 0) enable = 1'($urandom);
        if ($urandom_range(0, 3) == 0) image_select = 1'($urandom);
      end
    end
    tick(4);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
